line_mem_responder: RTL
=======================

Name: line_mem_responder

Overview:
- Responder end of the cache line-fill/write-back memory interface.
- Accepts one 256-bit line request at a time from the cache's mem_req_* port. Returns mem_resp_valid after a programmable latency.
- Backs lines with an on-chip single-port RAM. Never-written lines return a deterministic address pattern.
- Replaces the ad-hoc latency stub in synthesis and simulation tops.

Parameters:
- LINE_W, 256, line width in bits.
- ADDR_W, 15, line-address width (byte address >> 5).
- DEPTH_LOG2, 10, log2 of stored lines. Index = mem_req_addr[DEPTH_LOG2-1:0]; upper bits ignored (aliasing).
- RD_LAT, 20, read latency in cycles (legal 1..255).
- WR_LAT, 20, write latency in cycles (legal 1..255).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req_valid  in  1  request present; requester holds it until it sees mem_resp_valid.
- mem_req_rw  in  1  1 = write line, 0 = read line.
- mem_req_addr  in  ADDR_W  line address.
- mem_req_wdata  in  LINE_W  write data.
- mem_resp_valid  out  1  one-cycle completion pulse.
- mem_resp_rdata  out  LINE_W  read data; valid when mem_resp_valid is high for a read.
- mem_busy  out  1  high from acceptance through the response cycle.

Behaviour:
- Reset values:
  - mem_resp_valid=0, mem_resp_rdata=0, mem_busy=0.
  - State IDLE, latency counter 0, written-bitmap all 0.
  - RAM contents are not cleared.
- FSM IDLE -> WAIT -> RESP -> IDLE.
- IDLE:
  - mem_req_valid sampled high at a rising edge is accepted (edge A).
  - addr, rw and wdata are captured into registers. Inputs after A are ignored until IDLE is re-entered.
  - Counter loaded with LAT-1 (RD_LAT or WR_LAT per rw). Go to WAIT. mem_busy=1.
- WAIT:
  - Counter decrements each edge.
  - At the edge where the counter is 0, go to RESP.
  - For reads, the RAM read is issued on that edge.
- RESP: lasts one cycle.
  - mem_resp_valid is asserted at edge A+LAT+1 and deasserted at the next edge.
  - Read: mem_resp_rdata = RAM[idx] if bitmap[idx] is set, else {8{addr_q, 17'd0}} truncated/replicated to LINE_W.
  - Write: RAM[idx] <= wdata_q and bitmap[idx] <= 1, both at the RESP-entry edge. mem_resp_rdata holds its previous value.
- mem_resp_rdata holds its value between responses.
- mem_req_valid is ignored during RESP. The first cycle back in IDLE may accept a new request, including back-to-back write-back followed by fill. Minimum request-to-request spacing = LAT+2 cycles.
- Write then read of the same index: the read returns the new data, because the write is committed before IDLE is re-entered.
- Address aliasing: addr 0x0400 and 0x0000 map to the same line when DEPTH_LOG2=10.
- Reset mid-operation: the FSM returns to IDLE immediately and no response is issued. A pending write is dropped and the bitmap is cleared, so all lines read as pattern again.
- Latency values of 0 are out of contract. The implementation saturates them to 1.

Optional Feature:
- Macro LINE_MEM_STATS_EN.
- When defined: adds outputs stat_rd_cnt [15:0] and stat_wr_cnt [15:0].
  - Each increments on the RESP-entry edge for its request type.
  - Both wrap at 0xFFFF->0 and reset to 0.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package line_mem_pkg:
  - LINE_W and ADDR_W defaults.
  - FSM state enum (IDLE, WAIT, RESP).
  - Function line_pattern(addr) returning {8{addr, 17'd0}}.
- Sub-module line_mem_ram: single-port synchronous RAM with 1-cycle read and write-enable. The bitmap stays in the top module as a flop vector to allow async reset.

Test Plan:
- Read unwritten line: addr=0x0003, rw=0, RD_LAT=20 -> mem_resp_valid high exactly at edge A+21 for 1 cycle; rdata = {8{15'h0003,17'd0}}; mem_busy high edges A..A+21.
- Write then read: write addr=0x0010 with wdata=256'hA5..A5, then read 0x0010 -> write resp at A+21 with rdata unchanged; read returns A5..A5.
- Aliasing: write 0x0400 with data X (DEPTH_LOG2=10), then read 0x0000 -> returns X.
- Back-to-back: requester re-raises valid (new addr 0x0020, read) in the cycle after resp -> accepted on that edge; no lost or duplicated response.
- Valid held through RESP with unchanged fields -> exactly one response per handshake; a second response appears only after a new acceptance in IDLE.
- Reset asserted at WAIT count 5 -> no resp pulse; outputs are 0; a subsequent read of a previously written line returns the pattern. With LINE_MEM_STATS_EN: 3 reads + 2 writes -> stat_rd_cnt=3, stat_wr_cnt=2.

Source files
------------

// File: rtl/line_mem_pkg.sv
// line_mem_pkg: shared default widths, FSM state encoding and the unwritten-line fill pattern
package line_mem_pkg;
  localparam int LINE_W_D = 256;
  localparam int ADDR_W_D = 15;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  // A never-written line reads as its own address, shifted into the top of each 32-bit word.
  function automatic logic [LINE_W_D-1:0] line_pattern(input logic [ADDR_W_D-1:0] a);
    return {(LINE_W_D / (ADDR_W_D + 17)){a, 17'd0}};
  endfunction
endpackage

// File: rtl/line_mem_ram.sv
// line_mem_ram: single-port synchronous RAM, 1-cycle registered read, write has priority
//   clk      : clock
//   i_we     : write i_wdata to i_addr
//   i_re     : load o_rdata from i_addr
//   o_rdata  : read data, holds between reads
module line_mem_ram
  import line_mem_pkg::*;
#(
  parameter int W  = LINE_W_D,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [2**AW];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
    else if (i_re) o_rdata <= r_mem[i_addr];
endmodule

// File: rtl/line_mem_responder.sv
// line_mem_responder: memory-side responder for cache line fills and write-backs
//   clk, rst_n       : clock, asynchronous active-low reset
//   mem_req_*        : one line request at a time (valid, rw 1=write, addr, wdata)
//   mem_resp_valid   : one-cycle completion pulse, LAT+1 edges after acceptance
//   mem_resp_rdata   : read data, holds between responses
//   mem_busy         : acceptance through the response cycle
//   stat_rd_cnt/stat_wr_cnt : completed read/write counters, only with LINE_MEM_STATS_EN
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int LINE_W     = LINE_W_D,
  parameter int ADDR_W     = ADDR_W_D,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 20,
  parameter int WR_LAT     = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req_valid,
  input  logic              mem_req_rw,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic [LINE_W-1:0] mem_req_wdata,
  output logic              mem_resp_valid,
  output logic [LINE_W-1:0] mem_resp_rdata,
  output logic              mem_busy
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [15:0]       stat_rd_cnt,
  output logic [15:0]       stat_wr_cnt
`endif
);
  // A latency of 0 cannot be counted down, so it behaves as 1.
  localparam logic [7:0] RD_L = (RD_LAT < 1) ? 8'd1 : 8'(RD_LAT);
  localparam logic [7:0] WR_L = (WR_LAT < 1) ? 8'd1 : 8'(WR_LAT);
  state_t r_state, w_next;
  logic [7:0] r_cnt;
  logic r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata, w_ram_q;
  logic [2**DEPTH_LOG2-1:0] r_written;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic w_acc, w_go;
  assign w_idx = r_addr[DEPTH_LOG2-1:0];
  assign w_acc = r_state == IDLE && mem_req_valid;
  // The RAM access happens on the edge that enters RESP, so a write is
  // committed before IDLE is re-entered and read data is ready in RESP.
  assign w_go = r_state == WAIT && r_cnt == 8'd0;
  assign mem_busy = r_state != IDLE || mem_resp_valid;
  always_comb w_next = w_acc ? WAIT : w_go ? RESP : r_state == RESP ? IDLE : r_state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_rw <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_written <= '0;
      mem_resp_valid <= 1'b0;
      mem_resp_rdata <= '0;
    end else begin
      r_state <= w_next;
      mem_resp_valid <= r_state == RESP;
      if (w_acc) begin
        r_rw <= mem_req_rw;
        r_addr <= mem_req_addr;
        r_wdata <= mem_req_wdata;
        r_cnt <= (mem_req_rw ? WR_L : RD_L) - 8'd1;
      end else if (r_state == WAIT && r_cnt != 8'd0)
        r_cnt <= r_cnt - 8'd1;
      if (w_go && r_rw) r_written[w_idx] <= 1'b1;
      if (r_state == RESP && !r_rw)
        mem_resp_rdata <= r_written[w_idx] ? w_ram_q : line_pattern(r_addr);
    end
  line_mem_ram #(.W(LINE_W), .AW(DEPTH_LOG2)) u_ram (
    .clk    (clk),
    .i_we   (w_go && r_rw),
    .i_re   (w_go && !r_rw),
    .i_addr (w_idx),
    .i_wdata(r_wdata),
    .o_rdata(w_ram_q)
  );
`ifdef LINE_MEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
    end else if (w_go) begin
      if (r_rw) stat_wr_cnt <= stat_wr_cnt + 16'd1;
      else stat_rd_cnt <= stat_rd_cnt + 16'd1;
    end
`endif
endmodule
